// File: rtl/accum_cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, controller states, width defaults.
package accum_cpu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STA = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    LOAD_IR = 3'd1,
    OPERAND = 3'd2,
    EXEC    = 3'd3,
    WB      = 3'd4,
    HALT    = 3'd5
  } state_t;

endpackage

// File: rtl/accum_cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator CPU; owns AC, PC, IR, OPR, carry.
// Optional macro CTRL_SKIP_CARRY_EN turns SKZ with A[0]=1 into skip-on-carry.
module accum_cpu_controller
  import accum_cpu_pkg::*;
#(
  parameter int               DATA_W   = DEF_DATA_W,
  parameter int               ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  input  logic [DATA_W-1:0] add_result,
  input  logic              add_cout,
  output logic [DATA_W-1:0] ac,
  output logic              carry,
  output logic              zero,
  output logic              halted,
  output state_t            dbg_state
);

  state_t                      state, state_nxt;
  logic [ADDR_W-1:0]           pc;
  logic [DATA_W-1:0]           ir, opr;
  logic [DATA_W-ADDR_W-1:0]    opcode;
  logic [ADDR_W-1:0]           a_field;
  logic                        skip;

  assign opcode    = ir[DATA_W-1:ADDR_W];
  assign a_field   = ir[ADDR_W-1:0];
  assign zero      = (ac == '0);
  assign halted    = (state == HALT);
  assign add_a     = ac;
  assign add_b     = opr;
  assign mem_wdata = ac;
  assign dbg_state = state;

`ifdef CTRL_SKIP_CARRY_EN
  assign skip = a_field[0] ? carry : zero;
`else
  assign skip = zero;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = LOAD_IR;
      LOAD_IR: state_nxt = OPERAND;
      OPERAND: state_nxt = EXEC;
      EXEC: begin
        if (opcode == OP_HLT)      state_nxt = HALT;
        else if (opcode == OP_ADD) state_nxt = WB;
        else                       state_nxt = FETCH;
      end
      WB:      state_nxt = FETCH;
      HALT:    state_nxt = start ? FETCH : HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // Memory: mem_rd returns data on the following cycle; mem_wr commits mem_addr/mem_wdata
  // at the edge it is high. Both strobes are forced low while reset is asserted.
  always_comb begin
    mem_addr = pc;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    case (state)
      FETCH: mem_rd = 1'b1;
      OPERAND: begin
        mem_addr = a_field;
        mem_rd   = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);
      end
      EXEC: begin
        mem_addr = a_field;
        mem_wr   = (opcode == OP_STA);
      end
      default: ;
    endcase
    if (reset) begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      ac    <= '0;
      ir    <= '0;
      opr   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        LOAD_IR: begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        EXEC: begin
          case (opcode)
            OP_ADD: opr <= mem_rdata;
            OP_AND: ac  <= ac & mem_rdata;
            OP_XOR: ac  <= ac ^ mem_rdata;
            OP_LDA: ac  <= mem_rdata;
            OP_JMP: pc  <= a_field;
            OP_SKZ: if (skip) pc <= pc + ADDR_W'(1);
            default: ;
          endcase
        end
        // Adder sees AC and the OPR captured in EXEC, so its result is stable here.
        WB: begin
          ac    <= add_result;
          carry <= add_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_cpu_controller.sv
// Directed bench for accum_cpu_controller with a behavioural memory and adder.
module tb_accum_cpu_controller;
  import accum_cpu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] add_a, add_b, add_result;
  logic          add_cout;
  logic [DW-1:0] ac;
  logic          carry, zero, halted;
  state_t        dbg_state;

  int total = 0;
  int bad   = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] got [16];
  int               n_got = 0;
  logic [DW-1:0]    image [32];
  logic [DW-1:0]    mem   [32];
  logic             load_img = 1'b0;
  int               strobes;

  accum_cpu_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .add_a(add_a), .add_b(add_b), .add_result(add_result), .add_cout(add_cout),
    .ac(ac), .carry(carry), .zero(zero), .halted(halted), .dbg_state(dbg_state)
  );

  // clock / external adder / single-port memory
  always #5 clk = ~clk;

  assign {add_cout, add_result} = {1'b0, add_a} + {1'b0, add_b};

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 32; i++) mem[i] <= image[i];
    end else if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
      if (n_got < 16) got[n_got] <= {mem_addr, mem_wdata};
      n_got <= n_got + 1;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_image();
    for (int i = 0; i < 32; i++) image[i] = 8'h00;
  endtask

  task automatic load_image();
    load_img = 1'b1;
    cycles(1);
    load_img = 1'b0;
  endtask

  initial begin
    // program 1: arithmetic, store, xor-to-zero, skz, halt, jmp wrap
    clear_image();
    image[0]  = 8'hB0; image[1]  = 8'h51; image[2]  = 8'hD2; image[3] = 8'hB3;
    image[4]  = 8'h54; image[5]  = 8'hB5; image[6]  = 8'h95; image[7] = 8'h20;
    image[8]  = 8'hB0; image[9]  = 8'h00; image[10] = 8'hFE;
    image[30] = 8'hFF; image[31] = 8'h00;
    image[16] = 8'h95; image[17] = 8'h8A; image[18] = 8'h00;
    image[19] = 8'h49; image[20] = 8'h1A; image[21] = 8'h3C;
    cycles(1);
    load_image();
    cycles(1);

    check("rst_state",  dbg_state, FETCH);
    check("rst_ac",     ac, 8'h00);
    check("rst_carry",  carry, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_rd",     mem_rd, 1'b0);
    check("rst_wr",     mem_wr, 1'b0);

    reset = 1'b0;
    #1;
    check("fetch0_addr", mem_addr, 5'h00);
    check("fetch0_rd",   mem_rd, 1'b1);

    cycles(9);
    check("add1_ac",    ac, 8'h1F);
    check("add1_carry", carry, 1'b1);
    check("add1_next",  mem_addr, 5'h02);
    exp_q.push_back({5'h12, 8'h1F});
    cycles(4);
    check("sta_mem",  mem[18], 8'h1F);
    check("sta_next", mem_addr, 5'h03);
    cycles(9);
    check("add2_ac",    ac, 8'h63);
    check("add2_carry", carry, 1'b0);
    cycles(8);
    check("xor_ac",   ac, 8'h00);
    check("xor_zero", zero, 1'b1);
    check("skz_pc",   mem_addr, 5'h07);
    cycles(4);
    check("skz_state", dbg_state, FETCH);
    check("skz_skip",  mem_addr, 5'h09);
    cycles(4);
    check("hlt_halted", halted, 1'b1);
    check("hlt_state",  dbg_state, HALT);

    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (mem_rd || mem_wr) strobes++;
    end
    check("halt_strobes", strobes, 0);
    check("halt_hold",    halted, 1'b1);

    start = 1'b1;
    cycles(1);
    check("resume_state", dbg_state, FETCH);
    check("resume_pc",    mem_addr, 5'h0A);
    cycles(1);
    check("start_in_fetch", dbg_state, LOAD_IR);
    start = 1'b0;
    cycles(3);
    check("jmp1_pc", mem_addr, 5'h1E);
    cycles(4);
    check("jmp2_pc", mem_addr, 5'h1F);
    cycles(4);
    check("hlt31_halted", halted, 1'b1);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check("wrap_state", dbg_state, FETCH);
    check("wrap_pc",    mem_addr, 5'h00);

    // program 2: reset while STA is in EXEC
    reset = 1'b1;
    clear_image();
    image[0] = 8'hB0; image[1] = 8'hD2; image[16] = 8'h5A; image[18] = 8'h77;
    load_image();
    reset = 1'b0;
    cycles(4);
    check("mid_lda_ac", ac, 8'h5A);
    cycles(3);
    check("mid_exec",   dbg_state, EXEC);
    check("mid_wr_pre", mem_wr, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_wr_rst", mem_wr, 1'b0);
    cycles(1);
    check("mid_state", dbg_state, FETCH);
    check("mid_ac",    ac, 8'h00);
    check("mid_pc",    mem_addr, 5'h00);
    check("mid_mem",   mem[18], 8'h77);

    // program 3: ADD with carry, then SKZ A=1
    clear_image();
    image[0] = 8'hB0; image[1] = 8'h51; image[2] = 8'h21; image[3] = 8'hD3;
    image[4] = 8'h00; image[16] = 8'hAA; image[17] = 8'hB5; image[19] = 8'h00;
    load_image();
    reset = 1'b0;
    cycles(9);
    check("skc_ac",    ac, 8'h5F);
    check("skc_carry", carry, 1'b1);
    check("skc_zero",  zero, 1'b0);
`ifdef CTRL_SKIP_CARRY_EN
    cycles(4);
    check("skc_pc", mem_addr, 5'h04);
    cycles(4);
    check("skc_mem", mem[19], 8'h00);
`else
    exp_q.push_back({5'h13, 8'h5F});
    cycles(4);
    check("skc_pc", mem_addr, 5'h03);
    cycles(8);
    check("skc_mem", mem[19], 8'h5F);
`endif
    check("skc_halted", halted, 1'b1);

    // scoreboard: every store seen on the bus against the expected queue
    check("store_count", n_got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_got && i < 16; i++)
      check("store_data", got[i], exp_q[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
